// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared decode types, queue element and entry records
package issue_queue_pkg;
  typedef enum logic [3:0] {OP_NOP, OP_ADDIU, OP_ORI, OP_ADDU} op_e;
  typedef struct packed {
    logic num1_need;
    logic num2_need;
  } decode_require_t;
  typedef struct packed {
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  dest_addr;
    logic [4:0]  num1_addr;
    logic        num1_need;
    logic [31:0] num1;
    logic [4:0]  num2_addr;
    logic        num2_need;
    logic [31:0] num2;
  } issue_queue_element_t;
  typedef struct packed {
    issue_queue_element_t elem;
    logic                 valid;
    logic                 ready1;
    logic                 ready2;
  } iq_entry_t;
endpackage

// File: rtl/iq_operand_capture.sv
// iq_operand_capture: resolves one operand at enqueue and flags per-entry wakeups from the writeback bus
module iq_operand_capture #(
  parameter int DEPTH = 8
) (
  input  logic                  need,
  input  logic [4:0]            addr,
  input  logic [31:0]           imm,
  input  logic [31:0]           rf_rdata,
  input  logic [31:0]           reg_busy,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_addr,
  input  logic [31:0]           wb_data,
  input  logic [DEPTH-1:0]      ent_ready,
  input  logic [DEPTH-1:0][4:0] ent_addr,
  output logic                  res_ready,
  output logic [31:0]           res_value,
  output logic [DEPTH-1:0]      wake
);
  logic wb_hit;
  assign wb_hit = wb_valid && wb_addr == addr;
  assign res_ready = !need || addr == 5'd0 || wb_hit || !reg_busy[addr];
  assign res_value = !need ? imm : addr == 5'd0 ? 32'd0 : wb_hit ? wb_data : rf_rdata;
  always_comb
    for (int i = 0; i < DEPTH; i++)
      wake[i] = !ent_ready[i] && wb_valid && wb_addr == ent_addr[i] && wb_addr != 5'd0;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order operand-capturing issue FIFO; head issues once both operands are resolved
import issue_queue_pkg::*;
module issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  issue_queue_element_t enq_elem,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic [31:0]          reg_busy,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic [31:0]          wb_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output issue_queue_element_t iss_elem
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  iq_entry_t q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [DEPTH-1:0] r1, r2, wake1, wake2;
  logic [DEPTH-1:0][4:0] a1, a2;
  logic c1, c2, enq_fire, iss_fire;
  logic [31:0] v1, v2;
  iq_entry_t new_ent;
  assign rf_raddr1 = enq_elem.num1_addr;
  assign rf_raddr2 = enq_elem.num2_addr;
  assign enq_ready = count != FULL;
  assign iss_valid = q[head].valid && q[head].ready1 && q[head].ready2;
  assign enq_fire = enq_valid && enq_ready;
  assign iss_fire = iss_valid && iss_ready;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      a1[i] = q[i].elem.num1_addr;
      a2[i] = q[i].elem.num2_addr;
      r1[i] = q[i].ready1 || !q[i].valid;
      r2[i] = q[i].ready2 || !q[i].valid;
    end
    new_ent = '{elem: enq_elem, valid: 1'b1, ready1: c1, ready2: c2};
    new_ent.elem.num1 = v1;
    new_ent.elem.num2 = v2;
    iss_elem = q[head].elem;
    iss_elem.num1_need = 1'b0;
    iss_elem.num2_need = 1'b0;
  end
  iq_operand_capture #(.DEPTH(DEPTH)) u_cap1 (
    .need(enq_elem.num1_need), .addr(enq_elem.num1_addr), .imm(enq_elem.num1),
    .rf_rdata(rf_rdata1), .reg_busy(reg_busy), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .ent_ready(r1), .ent_addr(a1), .res_ready(c1), .res_value(v1), .wake(wake1)
  );
  iq_operand_capture #(.DEPTH(DEPTH)) u_cap2 (
    .need(enq_elem.num2_need), .addr(enq_elem.num2_addr), .imm(enq_elem.num2),
    .rf_rdata(rf_rdata2), .reg_busy(reg_busy), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .ent_ready(r2), .ent_addr(a2), .res_ready(c2), .res_value(v2), .wake(wake2)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1[i]) begin
          q[i].ready1 <= 1'b1;
          q[i].elem.num1 <= wb_data;
        end
        if (wake2[i]) begin
          q[i].ready2 <= 1'b1;
          q[i].elem.num2 <= wb_data;
        end
      end
      if (iss_fire) begin
        q[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (enq_fire) begin
        q[tail] <= new_ent;
        tail <= tail + 1'b1;
      end
      count <= count + {{AW{1'b0}}, enq_fire} - {{AW{1'b0}}, iss_fire};
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue
import issue_queue_pkg::*;
module tb_issue_queue;
  logic clk = 0, rst = 1, flush = 0, enq_valid = 0, enq_ready, wb_valid = 0, iss_valid, iss_ready = 0;
  issue_queue_element_t enq_elem = '0, iss_elem;
  logic [4:0] rf_raddr1, rf_raddr2, wb_addr = 0;
  logic [31:0] rf_rdata1, rf_rdata2, reg_busy = 0, wb_data = 0;
  int errors = 0, checks = 0;
  assign rf_rdata1 = 32'hA000_0000 | {27'd0, rf_raddr1};
  assign rf_rdata2 = 32'hA000_0000 | {27'd0, rf_raddr2};
  always #5 clk = ~clk;
  issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_elem(enq_elem), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .reg_busy(reg_busy), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_elem(iss_elem)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic issue_queue_element_t mk(input logic [31:0] pc, input op_e op,
      input logic [4:0] s1, input logic n1, input logic [4:0] s2, input logic n2, input logic [31:0] imm);
    mk = '0;
    mk.pc = pc;
    mk.op = op;
    mk.dest_addr = 5'd1;
    mk.num1_addr = s1;
    mk.num1_need = n1;
    mk.num1 = 32'hDEAD_DEAD;
    mk.num2_addr = s2;
    mk.num2_need = n2;
    mk.num2 = imm;
  endfunction
  task automatic enq(input issue_queue_element_t e);
    enq_elem = e;
    enq_valid = 1;
    step;
    enq_valid = 0;
  endtask
  task automatic drain(input logic [31:0] pc0, input int n, input string tag);
    iss_ready = 1;
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, {31'd0, iss_valid}, 32'd1);
      check({tag, "_pc"}, iss_elem.pc, pc0 + 32'(4 * k));
      step;
    end
    iss_ready = 0;
    check({tag, "_empty"}, {31'd0, iss_valid}, 32'd0);
  endtask
  initial begin
    step;
    step;
    rst = 0;
    check("reset_iss_valid", {31'd0, iss_valid}, 32'd0);
    check("reset_enq_ready", {31'd0, enq_ready}, 32'd1);
    enq(mk(32'h10, OP_ORI, 5'd0, 1'b1, 5'd2, 1'b0, 32'h5));
    check("ori_iss_valid", {31'd0, iss_valid}, 32'd1);
    check("ori_num1", iss_elem.num1, 32'd0);
    check("ori_num2", iss_elem.num2, 32'h5);
    check("ori_need1", {31'd0, iss_elem.num1_need}, 32'd0);
    check("ori_op", {28'd0, iss_elem.op}, {28'd0, OP_ORI});
    drain(32'h10, 1, "ori_drain");
    reg_busy = 32'h8;
    enq(mk(32'h20, OP_ADDIU, 5'd3, 1'b1, 5'd4, 1'b0, 32'h7));
    check("raddr1", {27'd0, rf_raddr1}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("wait_busy", {31'd0, iss_valid}, 32'd0);
      step;
    end
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h1234;
    check("wait_pre_wb", {31'd0, iss_valid}, 32'd0);
    step;
    wb_valid = 0; reg_busy = 0;
    check("wake_num1", iss_elem.num1, 32'h1234);
    check("wake_num2", iss_elem.num2, 32'h7);
    drain(32'h20, 1, "wake_drain");
    reg_busy = 32'h20;
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hBEEF;
    enq(mk(32'h30, OP_ADDU, 5'd5, 1'b1, 5'd6, 1'b1, 32'h0));
    wb_valid = 0; reg_busy = 0;
    check("bypass_num1", iss_elem.num1, 32'hBEEF);
    check("rf_num2", iss_elem.num2, 32'hA000_0006);
    drain(32'h30, 1, "bypass_drain");
    reg_busy = 32'h10;
    enq(mk(32'h40, OP_ADDIU, 5'd4, 1'b1, 5'd0, 1'b0, 32'h1));
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    step;
    check("r0_no_wake", {31'd0, iss_valid}, 32'd0);
    wb_addr = 5'd4; wb_data = 32'h44;
    step;
    wb_valid = 0; reg_busy = 0;
    check("r4_wake_num1", iss_elem.num1, 32'h44);
    drain(32'h40, 1, "r4_drain");
    for (int i = 0; i < 8; i++) begin
      check("fill_enq_ready", {31'd0, enq_ready}, 32'd1);
      enq(mk(32'h100 + 32'(4 * i), OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'(i)));
    end
    check("full_enq_ready", {31'd0, enq_ready}, 32'd0);
    check("full_head_pc", iss_elem.pc, 32'h100);
    enq_elem = mk(32'h200, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    enq_valid = 1; iss_ready = 1;
    step;
    enq_valid = 0; iss_ready = 0;
    check("after_full_iss_enq_ready", {31'd0, enq_ready}, 32'd1);
    drain(32'h104, 7, "order");
    for (int i = 0; i < 4; i++) enq(mk(32'h300 + 32'(4 * i), OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0));
    enq_elem = mk(32'h310, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    enq_valid = 1; iss_ready = 1;
    step;
    enq_valid = 0; iss_ready = 0;
    drain(32'h304, 4, "both");
    for (int i = 0; i < 5; i++) enq(mk(32'h400 + 32'(4 * i), OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0));
    flush = 1;
    enq_elem = mk(32'h500, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    enq_valid = 1;
    step;
    flush = 0; enq_valid = 0;
    check("flush_iss_valid", {31'd0, iss_valid}, 32'd0);
    check("flush_enq_ready", {31'd0, enq_ready}, 32'd1);
    step;
    step;
    check("flush_stays_empty", {31'd0, iss_valid}, 32'd0);
    enq(mk(32'h600, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0));
    drain(32'h600, 1, "post_flush");
    enq(mk(32'h700, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0));
    enq(mk(32'h704, OP_ORI, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0));
    rst = 1;
    step;
    rst = 0;
    check("midrst_iss_valid", {31'd0, iss_valid}, 32'd0);
    check("midrst_enq_ready", {31'd0, enq_ready}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >=2).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  flush  in  1  discard all entries (branch mispredict)
  enq_valid  in  1  decoder offers one ISSUE_QUEUE_ELEMENT
  enq_ready  out  1  queue accepts this cycle
  enq_elem  in  ISSUE_QUEUE_ELEMENT  decoded instruction
  rf_raddr1 / rf_raddr2  out  5  regfile read addresses, equal to enq_elem.num1_addr / num2_addr
  rf_rdata1 / rf_rdata2  in  32  combinational regfile read data
  reg_busy  in  32  external scoreboard; bit r set = register r has a pending writer
  wb_valid  in  1  writeback broadcast valid
  wb_addr  in  5  writeback destination register
  wb_data  in  32  writeback value
  iss_valid  out  1  head entry ready to execute
  iss_ready  in  1  execute stage accepts
  iss_elem  out  ISSUE_QUEUE_ELEMENT  head entry, operands resolved

Function
REQ-003 SHALL be an in-order FIFO of DEPTH entries; only the head entry may issue.
REQ-004 SHALL assert enq_ready iff not full; enqueue fires when enq_valid && enq_ready.
REQ-005 On enqueue, per operand k SHALL set ready_k=1 and keep enq_elem.num_k when num_k_need=0.
REQ-006 On enqueue with num_k_need=1: addr 0 -> value 0, ready; else wb_valid && wb_addr==addr -> wb_data, ready; else !reg_busy[addr] -> rf_rdata_k, ready; else ready_k=0, value don't-care.
REQ-007 Each cycle, every valid entry with ready_k=0 and wb_valid && wb_addr==num_k_addr && wb_addr!=0 SHALL capture wb_data and set ready_k.
REQ-008 iss_valid SHALL equal head valid && ready1 && ready2, from registered state only (no enqueue-to-issue or wb-to-issue combinational path).
REQ-009 Minimum latency enqueue->iss_valid SHALL be 1 cycle; wb capture->iss_valid 1 cycle.
REQ-010 iss_elem SHALL carry the stored element with num1/num2 = resolved values and num1_need/num2_need = 0; all other fields unchanged.
REQ-011 Issue fires when iss_valid && iss_ready; head pointer advances.
REQ-012 Simultaneous enqueue and issue SHALL both take effect; count unchanged.
REQ-013 Enqueue SHALL not be accepted when full even if issue fires that cycle.
REQ-014 Pointers SHALL wrap modulo DEPTH; full/empty distinguished by a count or extra pointer bit.
REQ-015 flush SHALL take priority: next cycle queue empty, enqueue and wb capture of that cycle discarded; issue handshake that cycle still counts as fired toward execute.
REQ-016 iss_valid and enq_ready SHALL not depend combinationally on iss_ready or enq_valid.
REQ-017 Writes to register 0 on the wb bus SHALL never wake any operand.

Reset
REQ-018 On rst: queue empty, pointers 0, all entry valid/ready bits 0; next cycle iss_valid=0, enq_ready=1; iss_elem don't-care.
REQ-019 rst mid-operation SHALL discard all entries; rst has priority over flush, enqueue, wb.

Structure
REQ-020 ISSUE_QUEUE_ELEMENT, DECODE_REQUIRE and enums SHALL remain in the shared defines package; entry record (element + valid + ready1 + ready2) SHALL be a package typedef.
REQ-021 One sub-module iq_operand_capture SHALL implement REQ-006/REQ-007 for one operand and be instantiated per operand.

Verification
REQ-022 Reset, enqueue ORI rs=0 imm=0x0005 -> one cycle later iss_valid=1, num1=0, num2=0x00000005.
REQ-023 reg_busy[3]=1, enqueue ADDIU rs=3; 4 cycles later wb 3=0x1234 -> iss_valid rises the following cycle, num1=0x00001234.
REQ-024 DEPTH=8, iss_ready=0, enqueue 8 independent instructions -> enq_ready=0 after 8th; 9th held; iss_ready=1 -> in-order issue, pc order preserved.
REQ-025 Enqueue with wb_valid, wb_addr==rs, reg_busy[rs]=1 same cycle -> value = wb_data (bypass), not rf_rdata.
REQ-026 Queue holding 5 entries, flush -> next cycle iss_valid=0, enq_ready=1, no stale entry issues.
REQ-027 wb_addr=0 wb_data=0xFFFFFFFF with entry waiting on r0-free operand -> no wakeup; simultaneous enq+iss at count 4 -> count stays 4.
